// File: rtl/gpr_file_if.sv
// Read/reserve/writeback bus of the gpr_file register file.
// master = pipeline side (decode + writeback), slave = register file.
interface gpr_file_if #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
);
    localparam int AW = $clog2(NREGS);

    logic [AW-1:0]   rs1_addr_in;
    logic [AW-1:0]   rs2_addr_in;
    logic [XLEN-1:0] rs1_data_out;
    logic [XLEN-1:0] rs2_data_out;
    logic            rs1_busy_out;
    logic            rs2_busy_out;
    logic            rd_we_in;
    logic [AW-1:0]   rd_addr_in;
    logic [XLEN-1:0] rd_data_in;
    logic            rsv_we_in;
    logic [AW-1:0]   rsv_addr_in;
    logic            flush_in;
    logic [AW:0]     busy_cnt_out;

    modport master (
        output rs1_addr_in, rs2_addr_in, rd_we_in, rd_addr_in, rd_data_in,
               rsv_we_in, rsv_addr_in, flush_in,
        input  rs1_data_out, rs2_data_out, rs1_busy_out, rs2_busy_out, busy_cnt_out
    );

    modport slave (
        input  rs1_addr_in, rs2_addr_in, rd_we_in, rd_addr_in, rd_data_in,
               rsv_we_in, rsv_addr_in, flush_in,
        output rs1_data_out, rs2_data_out, rs1_busy_out, rs2_busy_out, busy_cnt_out
    );
endinterface

// File: rtl/gpr_file.sv
// Parametrised GPR file with per-register busy scoreboard and busy counter.
// Optional write-to-read bypass enabled by defining GPR_BYPASS_EN.
module gpr_file #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input logic       clock_in,
    input logic       reset_in,
    gpr_file_if.slave bus
);
    localparam int AW = $clog2(NREGS);

    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] busy_nxt;
    logic [AW:0]      busy_cnt;

    logic wr_en;
    logic rsv_en;
    logic cnt_inc;
    logic cnt_dec;

    assign wr_en   = bus.rd_we_in  && (bus.rd_addr_in  != '0);
    assign rsv_en  = bus.rsv_we_in && (bus.rsv_addr_in != '0);
    assign cnt_inc = rsv_en && !busy[bus.rsv_addr_in];
    // A reserve of the register being released wins, so that release does not count.
    assign cnt_dec = wr_en && busy[bus.rd_addr_in]
                     && !(rsv_en && (bus.rsv_addr_in == bus.rd_addr_in));

    always_ff @(posedge clock_in or negedge reset_in) begin
        if (!reset_in) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[bus.rd_addr_in] <= bus.rd_data_in;
        end
    end

    always_comb begin
        busy_nxt = busy;
        if (bus.flush_in) begin
            busy_nxt = '0;
        end else begin
            if (wr_en) begin
                busy_nxt[bus.rd_addr_in] = 1'b0;
            end
            if (rsv_en) begin
                busy_nxt[bus.rsv_addr_in] = 1'b1;
            end
        end
    end

    always_ff @(posedge clock_in or negedge reset_in) begin
        if (!reset_in) begin
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            busy <= busy_nxt;
            if (bus.flush_in) begin
                busy_cnt <= '0;
            end else begin
                busy_cnt <= busy_cnt + {{AW{1'b0}}, cnt_inc} - {{AW{1'b0}}, cnt_dec};
            end
        end
    end

    assign bus.busy_cnt_out = busy_cnt;

    always_comb begin
        bus.rs1_data_out = regs[bus.rs1_addr_in];
        bus.rs2_data_out = regs[bus.rs2_addr_in];
        bus.rs1_busy_out = busy[bus.rs1_addr_in];
        bus.rs2_busy_out = busy[bus.rs2_addr_in];
`ifdef GPR_BYPASS_EN
        // Forward writeback data; the register is only busy again if re-reserved now.
        if (wr_en && (bus.rd_addr_in == bus.rs1_addr_in)) begin
            bus.rs1_data_out = bus.rd_data_in;
            bus.rs1_busy_out = rsv_en && (bus.rsv_addr_in == bus.rs1_addr_in);
        end
        if (wr_en && (bus.rd_addr_in == bus.rs2_addr_in)) begin
            bus.rs2_data_out = bus.rd_data_in;
            bus.rs2_busy_out = rsv_en && (bus.rsv_addr_in == bus.rs2_addr_in);
        end
`endif
    end
endmodule

// File: tb/tb_gpr_file.sv
// Directed + random self-checking bench for gpr_file with a reference model
// and an expected-value queue.
module tb_gpr_file;
    localparam int XLEN  = 32;
    localparam int NREGS = 32;

    logic clk;
    logic rst_n;

    gpr_file_if #(.XLEN(XLEN), .NREGS(NREGS)) bus ();

    gpr_file #(.XLEN(XLEN), .NREGS(NREGS)) dut (
        .clock_in (clk),
        .reset_in (rst_n),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] exp_q [$];
    int          n_checks = 0;
    int          n_fail   = 0;

    logic [XLEN-1:0] ref_regs [NREGS];
    logic            ref_busy [NREGS];

    task automatic model_reset();
        for (int i = 0; i < NREGS; i++) begin
            ref_regs[i] = '0;
            ref_busy[i] = 1'b0;
        end
    endtask

    function automatic logic [31:0] ref_cnt();
        logic [31:0] c;
        c = 0;
        for (int i = 0; i < NREGS; i++) c += {31'd0, ref_busy[i]};
        return c;
    endfunction

    function automatic logic [31:0] ref_data(input logic [4:0] a);
        logic [31:0] d;
        d = ref_regs[a];
`ifdef GPR_BYPASS_EN
        if (bus.rd_we_in && bus.rd_addr_in != 0 && bus.rd_addr_in == a) d = bus.rd_data_in;
`endif
        return d;
    endfunction

    function automatic logic [31:0] ref_bsy(input logic [4:0] a);
        logic b;
        b = ref_busy[a];
`ifdef GPR_BYPASS_EN
        if (bus.rd_we_in && bus.rd_addr_in != 0 && bus.rd_addr_in == a)
            b = bus.rsv_we_in && (bus.rsv_addr_in == a);
`endif
        return {31'd0, b};
    endfunction

    // Applies the current bench-driven inputs as of the coming rising edge.
    task automatic model_update();
        logic nb [NREGS];
        for (int i = 0; i < NREGS; i++) begin
            nb[i] = ref_busy[i];
            if (bus.flush_in) nb[i] = 1'b0;
            else if (bus.rsv_we_in && bus.rsv_addr_in == i && i != 0) nb[i] = 1'b1;
            else if (bus.rd_we_in && bus.rd_addr_in == i) nb[i] = 1'b0;
        end
        if (bus.rd_we_in && bus.rd_addr_in != 0) ref_regs[bus.rd_addr_in] = bus.rd_data_in;
        for (int i = 0; i < NREGS; i++) ref_busy[i] = nb[i];
    endtask

    task automatic push_exp(input logic [31:0] v);
        exp_q.push_back(v);
    endtask

    task automatic check(input string tag, input logic [31:0] obs);
        logic [31:0] exp;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s: expected queue empty, observed %h", tag, obs);
            return;
        end
        exp = exp_q.pop_front();
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Push model expectations, then compare at the falling edge.
    task automatic sample(input string tag);
        push_exp(ref_data(bus.rs1_addr_in));
        push_exp(ref_data(bus.rs2_addr_in));
        push_exp(ref_bsy(bus.rs1_addr_in));
        push_exp(ref_bsy(bus.rs2_addr_in));
        push_exp(ref_cnt());
        @(negedge clk);
        check({tag, ".rs1_data"}, bus.rs1_data_out);
        check({tag, ".rs2_data"}, bus.rs2_data_out);
        check({tag, ".rs1_busy"}, {31'd0, bus.rs1_busy_out});
        check({tag, ".rs2_busy"}, {31'd0, bus.rs2_busy_out});
        check({tag, ".busy_cnt"}, {26'd0, bus.busy_cnt_out});
    endtask

    task automatic commit();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.rd_we_in    = 1'b0;
        bus.rd_addr_in  = '0;
        bus.rd_data_in  = '0;
        bus.rsv_we_in   = 1'b0;
        bus.rsv_addr_in = '0;
        bus.flush_in    = 1'b0;
    endtask

    task automatic do_write(input logic [4:0] a, input logic [31:0] d);
        bus.rd_we_in = 1'b1; bus.rd_addr_in = a; bus.rd_data_in = d;
    endtask

    task automatic do_rsv(input logic [4:0] a);
        bus.rsv_we_in = 1'b1; bus.rsv_addr_in = a;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        bus.rs1_addr_in = '0;
        bus.rs2_addr_in = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Cleared state on every address, both ports
        for (int i = 0; i < NREGS; i++) begin
            bus.rs1_addr_in = 5'(i);
            bus.rs2_addr_in = 5'(NREGS - 1 - i);
            sample("reset");
            commit();
        end

        // Write x5, ignored write to x0
        do_write(5, 32'hDEADBEEF); sample("wr_x5"); commit();
        do_write(0, 32'h12345678); sample("wr_x0"); commit();
        idle(); bus.rs1_addr_in = 5; bus.rs2_addr_in = 0;
        sample("rd_x5_x0");
        push_exp(32'hDEADBEEF); check("x5_value", bus.rs1_data_out);
        push_exp(32'h0);        check("x0_value", bus.rs2_data_out);
        commit();

        // Reserve x7, x9; release x7
        do_rsv(7); sample("rsv_x7"); commit();
        idle(); do_rsv(9); sample("rsv_x9"); commit();
        idle(); bus.rs1_addr_in = 7; bus.rs2_addr_in = 9;
        sample("busy_7_9");
        push_exp(32'd2); check("cnt_two", {26'd0, bus.busy_cnt_out});
        push_exp(32'd1); check("busy_x7", {31'd0, bus.rs1_busy_out});
        commit();
        do_write(7, 32'h00000777); sample("rel_x7"); commit();
        idle(); sample("after_rel_x7");
        push_exp(32'd1); check("cnt_one", {26'd0, bus.busy_cnt_out});
        push_exp(32'd0); check("x7_free", {31'd0, bus.rs1_busy_out});
        commit();

        // Reserve wins over same-cycle release of the same register
        do_rsv(3); sample("rsv_x3"); commit();
        idle(); bus.rs1_addr_in = 3;
        do_rsv(3); do_write(3, 32'h33330003); sample("rsv_wr_x3"); commit();
        idle(); sample("after_x3");
        push_exp(32'h33330003); check("x3_data", bus.rs1_data_out);
        push_exp(32'd1);        check("x3_busy", {31'd0, bus.rs1_busy_out});
        push_exp(32'd2);        check("cnt_x3", {26'd0, bus.busy_cnt_out});
        commit();
        do_rsv(4); do_write(9, 32'h99); sample("rsv4_rel9"); commit();
        idle(); sample("after_4_9");
        push_exp(32'd2); check("cnt_net0", {26'd0, bus.busy_cnt_out});
        commit();

        // Flush beats a same-cycle reserve; write still lands
        do_rsv(1);  sample("rsv_x1");  commit();
        do_rsv(2);  sample("rsv_x2");  commit();
        do_rsv(31); sample("rsv_x31"); commit();
        idle(); bus.flush_in = 1'b1; do_rsv(6); do_write(12, 32'hC0C0C0C0);
        sample("flush"); commit();
        idle(); bus.rs1_addr_in = 6; bus.rs2_addr_in = 12;
        sample("after_flush");
        push_exp(32'd0);         check("flush_cnt", {26'd0, bus.busy_cnt_out});
        push_exp(32'd0);         check("flush_x6", {31'd0, bus.rs1_busy_out});
        push_exp(32'hC0C0C0C0);  check("flush_wr", bus.rs2_data_out);
        commit();

        // Same-cycle visibility of a write
        do_write(10, 32'h11111111); sample("pre_x10"); commit();
        idle(); bus.rs1_addr_in = 10; do_write(10, 32'hA5A5A5A5);
        sample("byp_x10");
`ifdef GPR_BYPASS_EN
        push_exp(32'hA5A5A5A5);
`else
        push_exp(32'h11111111);
`endif
        check("x10_same_cycle", bus.rs1_data_out);
        commit();
        idle(); sample("x10_next");
        push_exp(32'hA5A5A5A5); check("x10_next_cycle", bus.rs1_data_out);
        commit();

        // Random traffic against the model
        for (int n = 0; n < 300; n++) begin
            bus.rs1_addr_in = 5'($urandom_range(0, NREGS - 1));
            bus.rs2_addr_in = 5'($urandom_range(0, NREGS - 1));
            bus.rd_we_in    = 1'($urandom_range(0, 1));
            bus.rd_addr_in  = 5'($urandom_range(0, NREGS - 1));
            bus.rd_data_in  = $urandom;
            bus.rsv_we_in   = 1'($urandom_range(0, 1));
            bus.rsv_addr_in = 5'($urandom_range(0, NREGS - 1));
            bus.flush_in    = ($urandom_range(0, 15) == 0);
            sample("rand");
            commit();
        end

        // Asynchronous reset in the middle of a burst
        idle(); bus.rs1_addr_in = 13; bus.rs2_addr_in = 14;
        do_write(13, 32'hFACE0013); do_rsv(14); sample("burst0"); commit();
        do_write(14, 32'hFACE0014); do_rsv(13); sample("burst1"); commit();
        idle(); do_rsv(15);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        push_exp(32'd0); check("async_rs1_data", bus.rs1_data_out);
        push_exp(32'd0); check("async_rs2_data", bus.rs2_data_out);
        push_exp(32'd0); check("async_rs1_busy", {31'd0, bus.rs1_busy_out});
        push_exp(32'd0); check("async_cnt", {26'd0, bus.busy_cnt_out});
        idle();
        @(posedge clk); #1 rst_n = 1'b1;
        sample("post_reset");
        commit();

        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL leftover_queue: observed %0d entries expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no end expected end of test");
        $fatal(1, "timeout");
    end
endmodule
